// File: rtl/window_extrema_pkg.sv
// Shared types for the windowed extrema tracker.
// Pure declarations: no latency, no flow control.
package window_extrema_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Width able to hold a sample count of 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/extrema_cmp.sv
// Combinational magnitude compare of a against b, signed or unsigned by parameter.
// Zero latency; no flow control.
module extrema_cmp #(
    parameter int W      = 32,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         lt
);

    generate
        if (SIGNED != 0) begin : g_signed
            assign gt = $signed(a) > $signed(b);
            assign lt = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
            assign lt = a < b;
        end
    endgenerate

endmodule

// File: rtl/window_extrema.sv
// Running max/min (with first-occurrence index) over a window of N accepted samples.
// Outputs registered, 1-cycle latency; no backpressure, en is ignored once the window is full.
module window_extrema
    import window_extrema_pkg::*;
#(
    parameter int W      = 32,
    parameter int N      = 100,
    parameter int SIGNED = 0,
    localparam int CW    = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic [W-1:0]  X,
    output logic [W-1:0]  max_o,
    output logic [W-1:0]  min_o,
    output logic [CW-1:0] max_idx,
    output logic [CW-1:0] min_idx,
    output logic [CW-1:0] cnt,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [W-1:0]  max_q, max_d;
    logic [W-1:0]  min_q, min_d;
    logic [CW-1:0] max_idx_q, max_idx_d;
    logic [CW-1:0] min_idx_q, min_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic [CW-1:0] base_cnt;
    logic [CW-1:0] cnt_inc;
    logic          accept;
    logic          first;
    logic          last;
    logic          x_gt_max;
    logic          x_lt_min;
    logic          unused_max_lt;
    logic          unused_min_gt;

    extrema_cmp #(.W(W), .SIGNED(SIGNED)) u_cmp_max (
        .a  (X),
        .b  (max_q),
        .gt (x_gt_max),
        .lt (unused_max_lt)
    );

    extrema_cmp #(.W(W), .SIGNED(SIGNED)) u_cmp_min (
        .a  (X),
        .b  (min_q),
        .gt (unused_min_gt),
        .lt (x_lt_min)
    );

    // A start in the same cycle makes this sample index 0 of a fresh window.
    always_comb begin
        base_cnt = start ? '0 : cnt_q;
        cnt_inc  = base_cnt + CW'(1);
        accept   = en && (start || (state_q == ST_FILL));
        first    = (base_cnt == '0);
        last     = (cnt_inc == CW'(N));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        done_d    = 1'b0;

        if (start) begin
            state_d = ST_FILL;
            cnt_d   = '0;
        end

        if (accept) begin
            cnt_d = cnt_inc;
            // First sample overwrites stale results; later ones use strict compare.
            if (first || x_gt_max) begin
                max_d     = X;
                max_idx_d = base_cnt;
            end
            if (first || x_lt_min) begin
                min_d     = X;
                min_idx_d = base_cnt;
            end
            if (last) begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            done_q    <= done_d;
        end
    end

    assign max_o   = max_q;
    assign min_o   = min_q;
    assign max_idx = max_idx_q;
    assign min_idx = min_idx_q;
    assign cnt     = cnt_q;
    assign busy    = (state_q == ST_FILL);
    assign done    = done_q;

endmodule

// File: tb/tb_window_extrema.sv
// Self-checking bench for window_extrema: vector table, corner sequences, several parameter sets.
module tb_window_extrema;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Group A: W=32, N=4, unsigned
    logic        a_rst, a_start, a_en;
    logic [31:0] a_x, a_max, a_min;
    logic [2:0]  a_maxi, a_mini, a_cnt;
    logic        a_busy, a_done;

    window_extrema #(.W(32), .N(4), .SIGNED(0)) u_dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .en(a_en), .X(a_x),
        .max_o(a_max), .min_o(a_min), .max_idx(a_maxi), .min_idx(a_mini),
        .cnt(a_cnt), .busy(a_busy), .done(a_done)
    );

    // Group B: W=8, shared stimulus into signed N=3, unsigned N=3 and unsigned N=1
    logic       b_rst, b_start, b_en;
    logic [7:0] b_x;
    logic [7:0] s_max, s_min, u_max, u_min, o_max, o_min;
    logic [1:0] s_maxi, s_mini, s_cnt, u_maxi, u_mini, u_cnt;
    logic [0:0] o_maxi, o_mini, o_cnt;
    logic       s_busy, s_done, u_busy, u_done, o_busy, o_done;

    window_extrema #(.W(8), .N(3), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(b_rst), .start(b_start), .en(b_en), .X(b_x),
        .max_o(s_max), .min_o(s_min), .max_idx(s_maxi), .min_idx(s_mini),
        .cnt(s_cnt), .busy(s_busy), .done(s_done)
    );

    window_extrema #(.W(8), .N(3), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(b_rst), .start(b_start), .en(b_en), .X(b_x),
        .max_o(u_max), .min_o(u_min), .max_idx(u_maxi), .min_idx(u_mini),
        .cnt(u_cnt), .busy(u_busy), .done(u_done)
    );

    window_extrema #(.W(8), .N(1), .SIGNED(0)) u_dut_1 (
        .clk(clk), .rst(b_rst), .start(b_start), .en(b_en), .X(b_x),
        .max_o(o_max), .min_o(o_min), .max_idx(o_maxi), .min_idx(o_mini),
        .cnt(o_cnt), .busy(o_busy), .done(o_done)
    );

    // Group C: W=32, N=100, unsigned
    logic        c_rst, c_start, c_en;
    logic [31:0] c_x, c_max, c_min;
    logic [6:0]  c_maxi, c_mini, c_cnt;
    logic        c_busy, c_done;

    window_extrema #(.W(32), .N(100), .SIGNED(0)) u_dut_c (
        .clk(clk), .rst(c_rst), .start(c_start), .en(c_en), .X(c_x),
        .max_o(c_max), .min_o(c_min), .max_idx(c_maxi), .min_idx(c_mini),
        .cnt(c_cnt), .busy(c_busy), .done(c_done)
    );

    typedef struct {
        logic        rst, start, en;
        logic [31:0] x;
        logic [2:0]  cnt;
        logic [31:0] mx, mn;
        logic [2:0]  mxi, mni;
        logic        busy, done;
    } vec_t;

    vec_t vecs[16];
    vec_t exp_q[$];
    vec_t e;

    logic [7:0] bx [3];
    int acc, early, cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input int r, input int s, input int en, input logic [31:0] x,
                                input int c, input logic [31:0] mx, input int mxi,
                                input logic [31:0] mn, input int mni, input int bsy, input int dn);
        vec_t v;
        v.rst = (r != 0);   v.start = (s != 0);  v.en = (en != 0); v.x = x;
        v.cnt = 3'(c);      v.mx = mx;           v.mxi = 3'(mxi);
        v.mn = mn;          v.mni = 3'(mni);
        v.busy = (bsy != 0); v.done = (dn != 0);
        return v;
    endfunction

    task automatic hold_seq();
        for (int k = 0; k < 10; k++) begin
            a_rst = 1'b0; a_start = 1'b0; a_en = 1'b1; a_x = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            chk("hold.cnt", 32'(a_cnt), 4);
            chk("hold.max", a_max, 9);
            chk("hold.min", a_min, 3);
            chk("hold.done", 32'(a_done), 0);
        end
        chk("hold.max_idx", 32'(a_maxi), 1);
        chk("hold.min_idx", 32'(a_mini), 2);
        chk("hold.busy", 32'(a_busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_en = 1'b0; a_x = '0;
        b_rst = 1'b1; b_start = 1'b0; b_en = 1'b0; b_x = '0;
        c_rst = 1'b1; c_start = 1'b0; c_en = 1'b0; c_x = '0;
        bx[0] = 8'h7F; bx[1] = 8'h80; bx[2] = 8'h00;

        //             r s e  x             cnt mx mxi mn mni busy done
        vecs[0]  = mk(1,0,0, 0,             0,  0,  0, 0,  0,  1, 0);
        vecs[1]  = mk(0,0,1, 5,             1,  5,  0, 5,  0,  1, 0);
        vecs[2]  = mk(0,0,1, 9,             2,  9,  1, 5,  0,  1, 0);
        vecs[3]  = mk(0,0,1, 3,             3,  9,  1, 3,  2,  1, 0);
        vecs[4]  = mk(0,0,1, 9,             4,  9,  1, 3,  2,  0, 1);
        vecs[5]  = mk(0,0,1, 32'hFFFF_FFFF, 4,  9,  1, 3,  2,  0, 0);
        vecs[6]  = mk(0,1,1, 42,            1,  42, 0, 42, 0,  1, 0);
        vecs[7]  = mk(0,0,1, 7,             2,  42, 0, 7,  1,  1, 0);
        vecs[8]  = mk(0,1,0, 0,             0,  42, 0, 7,  1,  1, 0);
        vecs[9]  = mk(0,0,0, 0,             0,  42, 0, 7,  1,  1, 0);
        vecs[10] = mk(0,0,1, 100,           1,  100,0, 100,0,  1, 0);
        vecs[11] = mk(0,0,1, 1,             2,  100,0, 1,  1,  1, 0);
        vecs[12] = mk(0,0,1, 50,            3,  100,0, 1,  1,  1, 0);
        vecs[13] = mk(1,0,1, 77,            0,  0,  0, 0,  0,  1, 0);
        vecs[14] = mk(1,1,1, 8,             0,  0,  0, 0,  0,  1, 0);
        vecs[15] = mk(0,0,1, 8,             1,  8,  0, 8,  0,  1, 0);

        foreach (vecs[i]) begin
            a_rst = vecs[i].rst; a_start = vecs[i].start; a_en = vecs[i].en; a_x = vecs[i].x;
            exp_q.push_back(vecs[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            chk($sformatf("vec%0d.cnt", i),     32'(a_cnt),  32'(e.cnt));
            chk($sformatf("vec%0d.max", i),     a_max,       e.mx);
            chk($sformatf("vec%0d.max_idx", i), 32'(a_maxi), 32'(e.mxi));
            chk($sformatf("vec%0d.min", i),     a_min,       e.mn);
            chk($sformatf("vec%0d.min_idx", i), 32'(a_mini), 32'(e.mni));
            chk($sformatf("vec%0d.busy", i),    32'(a_busy), 32'(e.busy));
            chk($sformatf("vec%0d.done", i),    32'(a_done), 32'(e.done));
            if (i == 4) hold_seq();
        end

        // Signed vs unsigned ordering, plus the single-sample window.
        @(posedge clk); #1;
        chk("b.rst_busy", 32'(s_busy), 1);
        chk("b.rst_cnt", 32'(s_cnt), 0);
        b_rst = 1'b0; b_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_x = bx[k];
            @(posedge clk); #1;
            chk($sformatf("b.s_done%0d", k), 32'(s_done), (k == 2) ? 1 : 0);
            chk($sformatf("b.u_done%0d", k), 32'(u_done), (k == 2) ? 1 : 0);
            chk($sformatf("b.n1_done%0d", k), 32'(o_done), (k == 0) ? 1 : 0);
            chk($sformatf("b.n1_max%0d", k), 32'(o_max), 32'h7F);
        end
        chk("b.s_max", 32'(s_max), 32'h7F);
        chk("b.s_max_idx", 32'(s_maxi), 0);
        chk("b.s_min", 32'(s_min), 32'h80);
        chk("b.s_min_idx", 32'(s_mini), 1);
        chk("b.u_max", 32'(u_max), 32'h80);
        chk("b.u_max_idx", 32'(u_maxi), 1);
        chk("b.u_min", 32'(u_min), 32'h00);
        chk("b.u_min_idx", 32'(u_mini), 2);
        chk("b.n1_cnt", 32'(o_cnt), 1);
        chk("b.n1_busy", 32'(o_busy), 0);
        b_en = 1'b0;
        @(posedge clk); #1;
        chk("b.s_done_once", 32'(s_done), 0);
        chk("b.s_busy_hold", 32'(s_busy), 0);
        b_start = 1'b1; b_en = 1'b1; b_x = 8'h80;
        @(posedge clk); #1;
        b_start = 1'b0; b_en = 1'b0;
        chk("b.n1_restart_done", 32'(o_done), 1);
        chk("b.n1_restart_max", 32'(o_max), 32'h80);
        chk("b.s_restart_cnt", 32'(s_cnt), 1);
        chk("b.s_restart_max", 32'(s_max), 32'h80);
        chk("b.s_restart_min", 32'(s_min), 32'h80);
        chk("b.s_restart_busy", 32'(s_busy), 1);

        // Long window with random en gaps over a ramp.
        @(posedge clk); #1;
        c_rst = 1'b0;
        acc = 0; early = 0; cyc = 0;
        while (acc < 100 && cyc < 2000) begin
            c_en = ($urandom_range(0, 3) != 0);
            c_x  = 32'(acc);
            @(posedge clk); #1;
            cyc++;
            if (c_en) acc++;
            if (acc < 100 && c_done) early++;
        end
        c_en = 1'b0;
        chk("c.accepted", 32'(acc), 100);
        chk("c.early_done", 32'(early), 0);
        chk("c.done", 32'(c_done), 1);
        chk("c.cnt", 32'(c_cnt), 100);
        chk("c.max", c_max, 99);
        chk("c.max_idx", 32'(c_maxi), 99);
        chk("c.min", c_min, 0);
        chk("c.min_idx", 32'(c_mini), 0);
        chk("c.busy", 32'(c_busy), 0);
        @(posedge clk); #1;
        chk("c.done_pulse", 32'(c_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
